// File: rtl/jt12_pkg.sv
// ----------------------------------------------------------------------------
// jt12_pkg
//   Shared definitions for the JT12 output path.
//   - JT12_MIX_W : width of the signed stereo mix coming out of the mixer
//   - JT12_DAC_W : width of the signed samples handed to the DAC interface
//   - att_step_t : per-sample decision of the automatic attenuator
// ----------------------------------------------------------------------------
package jt12_pkg;

    localparam int JT12_MIX_W = 20;
    localparam int JT12_DAC_W = 16;

    // Direction in which the attenuation shift moves on an accepted sample.
    typedef enum logic [1:0] {
        ATT_HOLD,
        ATT_UP,
        ATT_DOWN
    } att_step_t;

endpackage : jt12_pkg

// File: rtl/jt12_autoatt_ch.sv
// ----------------------------------------------------------------------------
// jt12_autoatt_ch
//   One channel of the automatic attenuator, purely combinational.
//   Arithmetic-right-shifts the wide mix by the current attenuation, then
//   saturates to the DAC width.
//
//   Ports:
//     din_i   in  WIN   signed input sample
//     sh_i    in  SHW   current attenuation shift
//     dout_o  out WOUT  shifted and saturated sample
//     clip_o  out 1     shifted value does not fit in WOUT bits
//     quiet_o out 1     shifted value would still fit one shift step lower
// ----------------------------------------------------------------------------
module jt12_autoatt_ch #(
    parameter int WIN  = 20,
    parameter int WOUT = 16,
    parameter int SHW  = 2
) (
    input  logic signed [WIN-1:0]  din_i,
    input  logic        [SHW-1:0]  sh_i,
    output logic signed [WOUT-1:0] dout_o,
    output logic                   clip_o,
    output logic                   quiet_o
);

    logic signed [WIN-1:0] y;
    logic                  fits;

    assign y = din_i >>> sh_i;

    // A value fits in N signed bits when every bit from N-1 up is a copy of
    // the sign bit; "quiet" is the same test one bit narrower.
    assign fits    = (y[WIN-1:WOUT-1] == {(WIN-WOUT+1){y[WIN-1]}});
    assign quiet_o = (y[WIN-1:WOUT-2] == {(WIN-WOUT+2){y[WIN-1]}});
    assign clip_o  = ~fits;

    assign dout_o = fits       ? y[WOUT-1:0]
                  : y[WIN-1]   ? {1'b1, {(WOUT-1){1'b0}}}
                               : {1'b0, {(WOUT-1){1'b1}}};

endmodule : jt12_autoatt_ch

// File: rtl/jt12_autoatt.sv
// ----------------------------------------------------------------------------
// jt12_autoatt
//   Automatic stereo attenuator between the channel mixer and the DAC.
//   Each accepted sample is shifted right by an adaptive amount `sh`
//   (0..MAXSH, 6 dB per step) and saturated to WOUT bits. Clipping raises
//   `sh` by one immediately; HOLD consecutive quiet samples lower it by one.
//
//   Ports:
//     clk        in  1      system clock
//     rst        in  1      synchronous, active-high reset
//     sample     in  1      strobe, inputs valid this cycle
//     left_in    in  WIN    signed left mix
//     right_in   in  WIN    signed right mix
//     left_out   out WOUT   attenuated left (registered)
//     right_out  out WOUT   attenuated right (registered)
//     out_valid  out 1      one-cycle pulse the cycle after a sample
//     att        out SHW    current shift `sh` (registered)
//     clip_cnt   out 8      only with JT12_AUTOATT_CLIPCNT_EN: saturating
//                           count of samples that clipped while sh==MAXSH
//
//   Optional feature macro: JT12_AUTOATT_CLIPCNT_EN
// ----------------------------------------------------------------------------
module jt12_autoatt
    import jt12_pkg::*;
#(
    parameter int WIN   = JT12_MIX_W,
    parameter int WOUT  = JT12_DAC_W,
    parameter int MAXSH = 3,
    parameter int HOLD  = 1024,
    localparam int SHW  = $clog2(MAXSH + 1),
    localparam int HW   = $clog2(HOLD)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample,
    input  logic signed [WIN-1:0]  left_in,
    input  logic signed [WIN-1:0]  right_in,
    output logic signed [WOUT-1:0] left_out,
    output logic signed [WOUT-1:0] right_out,
    output logic                   out_valid,
`ifdef JT12_AUTOATT_CLIPCNT_EN
    output logic        [7:0]      clip_cnt,
`endif
    output logic        [SHW-1:0]  att
);

    logic        [SHW-1:0]  sh_q, sh_d;
    logic        [HW-1:0]   hold_q, hold_d;
    logic signed [WOUT-1:0] left_q, right_q;
    logic                   valid_q;

    logic signed [WOUT-1:0] left_sat, right_sat;
    logic                   clip_l, clip_r, quiet_l, quiet_r;
    logic                   clip_any, quiet_both;
    att_step_t              step;

    jt12_autoatt_ch #(.WIN(WIN), .WOUT(WOUT), .SHW(SHW)) u_left (
        .din_i  (left_in),
        .sh_i   (sh_q),
        .dout_o (left_sat),
        .clip_o (clip_l),
        .quiet_o(quiet_l)
    );

    jt12_autoatt_ch #(.WIN(WIN), .WOUT(WOUT), .SHW(SHW)) u_right (
        .din_i  (right_in),
        .sh_i   (sh_q),
        .dout_o (right_sat),
        .clip_o (clip_r),
        .quiet_o(quiet_r)
    );

    assign clip_any   = clip_l | clip_r;
    assign quiet_both = quiet_l & quiet_r;

    // Gain decision. Clipping outranks release, so a sample can never both
    // raise and lower the shift, and each sample moves it by at most one.
    always_comb begin
        // NOTE: every output of this block is assigned up front so no path
        // leaves one unassigned; that is what keeps it free of latches.
        step   = ATT_HOLD;
        hold_d = hold_q;
        sh_d   = sh_q;
        if (sample) begin
            if (clip_any) begin
                hold_d = '0;
                if (sh_q != SHW'(MAXSH)) step = ATT_UP;
            end else if (quiet_both && sh_q != '0) begin
                if (hold_q == HW'(HOLD - 1)) begin
                    step   = ATT_DOWN;
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end else begin
                hold_d = '0;
            end
        end
        case (step)
            ATT_UP:   sh_d = sh_q + SHW'(1);
            ATT_DOWN: sh_d = sh_q - SHW'(1);
            default:  sh_d = sh_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            hold_q  <= '0;
            left_q  <= '0;
            right_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            hold_q  <= hold_d;
            valid_q <= sample;
            if (sample) begin
                left_q  <= left_sat;
                right_q <= right_sat;
            end
        end
    end

`ifdef JT12_AUTOATT_CLIPCNT_EN
    logic [7:0] clip_cnt_q, clip_cnt_d;

    // Counts only clipping the attenuator can no longer absorb; sticks at 255.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (sample && clip_any && sh_q == SHW'(MAXSH) && clip_cnt_q != 8'hFF)
            clip_cnt_d = clip_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) clip_cnt_q <= '0;
        else     clip_cnt_q <= clip_cnt_d;
    end

    assign clip_cnt = clip_cnt_q;
`endif

    assign left_out  = left_q;
    assign right_out = right_q;
    assign out_valid = valid_q;
    assign att       = sh_q;

endmodule : jt12_autoatt

// File: tb/tb_jt12_autoatt.sv
// ----------------------------------------------------------------------------
// tb_jt12_autoatt
//   Self-checking bench for jt12_autoatt with HOLD=4. A behavioural model
//   built on plain integer arithmetic predicts each output; predictions are
//   queued when a sample is driven and popped when the DUT presents it.
//   Compile with +define+JT12_AUTOATT_CLIPCNT_EN to also check clip_cnt.
// ----------------------------------------------------------------------------
module tb_jt12_autoatt;
    import jt12_pkg::*;

    localparam int WIN   = JT12_MIX_W;
    localparam int WOUT  = JT12_DAC_W;
    localparam int MAXSH = 3;
    localparam int HOLD  = 4;
    localparam int SHW   = $clog2(MAXSH + 1);
    localparam int OMAX  = (1 << (WOUT - 1)) - 1;
    localparam int OMIN  = -(1 << (WOUT - 1));
    localparam int QMAX  = (1 << (WOUT - 2)) - 1;
    localparam int QMIN  = -(1 << (WOUT - 2));

    typedef logic [WOUT-1:0] dac_t;
    typedef logic [SHW-1:0]  att_t;
    typedef struct {
        int l;
        int r;
        int a;
        int cnt;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   sample;
    logic signed [WIN-1:0]  left_in, right_in;
    logic signed [WOUT-1:0] left_out, right_out;
    logic                   out_valid;
    logic        [SHW-1:0]  att;
`ifdef JT12_AUTOATT_CLIPCNT_EN
    logic        [7:0]      clip_cnt;
`endif

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_sh, m_hold, m_cnt;
    int   last_l, last_r;

    always #5 clk = ~clk;

    jt12_autoatt #(.WIN(WIN), .WOUT(WOUT), .MAXSH(MAXSH), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .sample   (sample),
        .left_in  (left_in),
        .right_in (right_in),
        .left_out (left_out),
        .right_out(right_out),
        .out_valid(out_valid),
`ifdef JT12_AUTOATT_CLIPCNT_EN
        .clip_cnt (clip_cnt),
`endif
        .att      (att)
    );

    // Reference channel: shift, range checks and saturation on 32-bit ints.
    function automatic void ch_model(input int x, input int sh,
                                     output int o, output bit c, output bit q);
        int y;
        y = x >>> sh;
        c = (y > OMAX) || (y < OMIN);
        q = (y >= QMIN) && (y <= QMAX);
        o = c ? ((y < 0) ? OMIN : OMAX) : y;
    endfunction

    function automatic int rand_mix();
        if ($urandom_range(0, 1) == 0)
            return int'($urandom_range(0, (1 << WIN) - 1)) - (1 << (WIN - 1));
        return int'($urandom_range(0, 40000)) - 20000;
    endfunction

    task automatic model_reset();
        m_sh = 0; m_hold = 0; m_cnt = 0; last_l = 0; last_r = 0;
        sb.delete();
    endtask

    // Drive one accepted sample, predict its result, advance one clock.
    task automatic drive(input int l, input int r);
        int   ol, orr;
        bit   cl, cr, ql, qr;
        exp_t e;
        ch_model(l, m_sh, ol, cl, ql);
        ch_model(r, m_sh, orr, cr, qr);
        if (cl || cr) begin
            if (m_sh < MAXSH) m_sh++;
            else if (m_cnt < 255) m_cnt++;
            m_hold = 0;
        end else if (ql && qr && m_sh > 0) begin
            if (m_hold == HOLD - 1) begin m_sh--; m_hold = 0; end
            else m_hold++;
        end else begin
            m_hold = 0;
        end
        e = '{l: ol, r: orr, a: m_sh, cnt: m_cnt};
        sb.push_back(e);
        last_l = ol; last_r = orr;
        sample   = 1'b1;
        left_in  = WIN'(l);
        right_in = WIN'(r);
        @(posedge clk); #1;
        sample = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; sample = 1'b1; left_in = WIN'(40000); right_in = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || left_out !== '0 || right_out !== '0 || att !== '0) begin
                n_bad++;
                $display("FAIL reset[%0d]: got v=%b l=%0d r=%0d att=%0d, want v=0 l=0 r=0 att=0",
                         i, out_valid, left_out, right_out, att);
            end
        end
        rst = 1'b0; sample = 1'b0;
    endtask

    task automatic test_passthrough();
        exp_t e;
        drive(1000, -1000);
        e = sb.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || left_out !== dac_t'(e.l) || right_out !== dac_t'(e.r) ||
            att !== att_t'(e.a)) begin
            n_bad++;
            $display("FAIL passthrough: got v=%b l=%0d r=%0d att=%0d, want v=1 l=%0d r=%0d att=%0d",
                     out_valid, left_out, right_out, att, e.l, e.r, e.a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0 || left_out !== dac_t'(last_l)) begin
            n_bad++;
            $display("FAIL pulse_width: got v=%b l=%0d, want v=0 l=%0d", out_valid, left_out, last_l);
        end
    endtask

    task automatic test_attack();
        int   ins[4] = '{40000, 40000, -40000, -40000};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) apply_reset();
            drive(ins[i], 0);
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || left_out !== dac_t'(e.l) || right_out !== dac_t'(e.r) ||
                att !== att_t'(e.a)) begin
                n_bad++;
                $display("FAIL attack[%0d]: got v=%b l=%0d r=%0d att=%0d, want v=1 l=%0d r=%0d att=%0d",
                         i, out_valid, left_out, right_out, att, e.l, e.r, e.a);
            end
        end
    endtask

    // 40000 at sh=0 sets att=1, then four quiet samples release it and the
    // fifth passes 10000 through unattenuated.
    task automatic test_release();
        int   ins[6] = '{40000, 10000, 10000, 10000, 10000, 10000};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(ins[i], -ins[i] / 2);
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || left_out !== dac_t'(e.l) || right_out !== dac_t'(e.r) ||
                att !== att_t'(e.a)) begin
                n_bad++;
                $display("FAIL release[%0d]: got v=%b l=%0d r=%0d att=%0d, want v=1 l=%0d r=%0d att=%0d",
                         i, out_valid, left_out, right_out, att, e.l, e.r, e.a);
            end
        end
    endtask

    // A loud-but-unclipped sample at hold count 3 restarts the count.
    task automatic test_release_interrupt();
        int   ins[9] = '{40000, 10000, 10000, 10000, 40000, 10000, 10000, 10000, 10000};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            drive(ins[i], 0);
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || left_out !== dac_t'(e.l) || att !== att_t'(e.a)) begin
                n_bad++;
                $display("FAIL release_interrupt[%0d]: got v=%b l=%0d att=%0d, want v=1 l=%0d att=%0d",
                         i, out_valid, left_out, att, e.l, e.a);
            end
        end
    endtask

    // Full-scale input walks att 1,2,3 and then saturates at MAXSH.
    task automatic test_max_att();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 303; i++) begin
            drive(524287, -524288);
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || left_out !== dac_t'(e.l) || right_out !== dac_t'(e.r) ||
                att !== att_t'(e.a)) begin
                n_bad++;
                $display("FAIL max_att[%0d]: got v=%b l=%0d r=%0d att=%0d, want v=1 l=%0d r=%0d att=%0d",
                         i, out_valid, left_out, right_out, att, e.l, e.r, e.a);
            end
`ifdef JT12_AUTOATT_CLIPCNT_EN
            n_cmp++;
            if (clip_cnt !== 8'(e.cnt)) begin
                n_bad++;
                $display("FAIL clip_cnt[%0d]: got %0d, want %0d", i, clip_cnt, e.cnt);
            end
`endif
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            left_in  = WIN'(rand_mix());
            right_in = WIN'(rand_mix());
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0 || left_out !== dac_t'(last_l) || right_out !== dac_t'(last_r) ||
                att !== att_t'(m_sh)) begin
                n_bad++;
                $display("FAIL idle[%0d]: got v=%b l=%0d r=%0d att=%0d, want v=0 l=%0d r=%0d att=%0d",
                         i, out_valid, left_out, right_out, att, last_l, last_r, m_sh);
            end
        end
    endtask

    // Build up hold=2 at att=1, then reset with a clipping strobe present.
    task automatic test_rst_mid_release();
        int   ins[3] = '{40000, 10000, 10000};
        exp_t e;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(ins[i], 0);
            e = sb.pop_front();
            n_cmp++;
            if (att !== att_t'(e.a) || left_out !== dac_t'(e.l)) begin
                n_bad++;
                $display("FAIL rst_mid_setup[%0d]: got l=%0d att=%0d, want l=%0d att=%0d",
                         i, left_out, att, e.l, e.a);
            end
        end
        rst = 1'b1; sample = 1'b1; left_in = WIN'(40000);
        @(posedge clk); #1;
        rst = 1'b0; sample = 1'b0;
        model_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || left_out !== '0 || right_out !== '0 || att !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_release: got v=%b l=%0d r=%0d att=%0d, want v=0 l=0 r=0 att=0",
                     out_valid, left_out, right_out, att);
        end
        drive(10000, 10000);
        e = sb.pop_front();
        n_cmp++;
        if (out_valid !== 1'b1 || left_out !== dac_t'(e.l) || att !== att_t'(e.a)) begin
            n_bad++;
            $display("FAIL rst_mid_after: got v=%b l=%0d att=%0d, want v=1 l=%0d att=%0d",
                     out_valid, left_out, att, e.l, e.a);
        end
    endtask

    // Strobes on consecutive cycles with random mixes at full rate.
    task automatic test_back_to_back();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 60; i++) begin
            drive(rand_mix(), rand_mix());
            e = sb.pop_front();
            n_cmp++;
            if (out_valid !== 1'b1 || left_out !== dac_t'(e.l) || right_out !== dac_t'(e.r) ||
                att !== att_t'(e.a)) begin
                n_bad++;
                $display("FAIL back_to_back[%0d]: got v=%b l=%0d r=%0d att=%0d, want v=1 l=%0d r=%0d att=%0d",
                         i, out_valid, left_out, right_out, att, e.l, e.r, e.a);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sample = 1'b0; left_in = '0; right_in = '0;
        test_reset();
        test_passthrough();
        test_attack();
        test_release();
        test_release_interrupt();
        test_max_att();
        test_idle();
        test_rst_mid_release();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_jt12_autoatt
